// File: rtl/replica_pkg.sv
// Shared command types and scheduler definitions for the replica node array.
package replica_pkg;

  typedef logic [2:0] opt_command_t;
  typedef logic [4:0] distance_command_t;

  localparam opt_command_t      OPT_IDLE      = 3'd0;
  localparam distance_command_t DIS_IDLE      = 5'd0;
  localparam int                DIS_STEPS_MAX = 16;

  // Delta-distance command issued at each step of the DIST phase.
  localparam distance_command_t DIS_SEQ [DIS_STEPS_MAX] = '{
    5'h03, 5'h05, 5'h09, 5'h11, 5'h06, 5'h0A, 5'h12, 5'h0C,
    5'h14, 5'h18, 5'h07, 5'h0B, 5'h13, 5'h0D, 5'h15, 5'h19
  };

  typedef enum logic [3:0] {
    IDLE, OPT, DIST, METRO, METRO_W,
    OR_REPL, OR_EXCH, OR_EXCH_W,
    TW_REPL, TW_EXCH, TW_EXCH_W,
    NEXT, DONE
  } sched_state_t;

endpackage

// File: rtl/sched_wait_cnt.sv
// Small load/decrement counter used to time the settle waits after metropolis and exchange.
module sched_wait_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [2:0] cnt_q, cnt_d;

  // Load takes priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= 3'd0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 3'd0);

endmodule

// File: rtl/node_sched.sv
// Per-node command sequencer: opt, delta-distance, metropolis and serialized replica/exchange.
module node_sched
  import replica_pkg::*;
#(
  parameter int DIS_STEPS = 4,
  parameter int METRO_LAT = 2,
  parameter int EXCH_LAT  = 3,
  parameter int ITER_W    = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ITER_W-1:0] iter_num,
  input  logic [7:0]        repl_interval,
  input  opt_command_t      opt_mode,
  output logic              opt_run,
  output opt_command_t      opt_com,
  output distance_command_t or_distance_com,
  output distance_command_t tw_distance_com,
  output logic              or_metropolis_run,
  output logic              tw_metropolis_run,
  output logic              or_replica_run,
  output logic              tw_replica_run,
  output logic              or_exchange_run,
  output logic              tw_exchange_run,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt
);

  // The counter is loaded with LAT-1 so the wait state lasts exactly LAT cycles.
  localparam logic [2:0] METRO_LOAD = 3'((METRO_LAT > 0) ? METRO_LAT - 1 : 0);
  localparam logic [2:0] EXCH_LOAD  = 3'((EXCH_LAT > 0) ? EXCH_LAT - 1 : 0);
  localparam logic [3:0] STEP_LAST  = 4'(DIS_STEPS - 1);

  sched_state_t      state_q, state_d;
  logic [ITER_W-1:0] iter_num_q, iter_num_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [7:0]        repl_q, repl_d;
  logic [7:0]        ivl_q, ivl_d;
  opt_command_t      opt_q, opt_d;
  logic [3:0]        step_q, step_d;

  logic              opt_run_q, opt_run_d;
  distance_command_t dis_q, dis_d;
  logic              metro_q, metro_d;
  logic              or_repl_q, or_repl_d;
  logic              tw_repl_q, tw_repl_d;
  logic              or_exch_q, or_exch_d;
  logic              tw_exch_q, tw_exch_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              wait_load, wait_dec, wait_zero;
  logic [2:0]        wait_val;
  logic              metro_exit, is_repl;

  sched_wait_cnt u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_load),
    .load_val (wait_val),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

  // Next-state, run bookkeeping and wait-counter control.
  always_comb begin
    state_d    = state_q;
    iter_num_d = iter_num_q;
    iter_cnt_d = iter_cnt_q;
    repl_d     = repl_q;
    ivl_d      = ivl_q;
    opt_d      = opt_q;
    step_d     = step_q;
    wait_load  = 1'b0;
    wait_val   = 3'd0;
    wait_dec   = 1'b0;
    metro_exit = 1'b0;
    is_repl    = (repl_q != 8'd0) && ((ivl_q + 8'd1) == repl_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (iter_num == '0) begin
            state_d = DONE;
          end else begin
            iter_num_d = iter_num;
            repl_d     = repl_interval;
            opt_d      = opt_mode;
            iter_cnt_d = '0;
            ivl_d      = 8'd0;
            state_d    = OPT;
          end
        end
      end
      OPT: begin
        step_d  = 4'd0;
        state_d = DIST;
      end
      DIST: begin
        if (step_q == STEP_LAST) state_d = METRO;
        else                     step_d  = step_q + 4'd1;
      end
      METRO: begin
        wait_load = 1'b1;
        wait_val  = METRO_LOAD;
        if (METRO_LAT == 0) metro_exit = 1'b1;
        else                state_d    = METRO_W;
      end
      METRO_W: begin
        wait_dec = 1'b1;
        if (wait_zero) metro_exit = 1'b1;
      end
      OR_REPL: state_d = OR_EXCH;
      OR_EXCH: begin
        wait_load = 1'b1;
        wait_val  = EXCH_LOAD;
        state_d   = (EXCH_LAT == 0) ? TW_REPL : OR_EXCH_W;
      end
      OR_EXCH_W: begin
        wait_dec = 1'b1;
        if (wait_zero) state_d = TW_REPL;
      end
      TW_REPL: state_d = TW_EXCH;
      TW_EXCH: begin
        wait_load = 1'b1;
        wait_val  = EXCH_LOAD;
        state_d   = (EXCH_LAT == 0) ? NEXT : TW_EXCH_W;
      end
      TW_EXCH_W: begin
        wait_dec = 1'b1;
        if (wait_zero) state_d = NEXT;
      end
      NEXT: begin
        iter_cnt_d = iter_cnt_q + ITER_W'(1);
        if (((iter_cnt_q + ITER_W'(1)) == iter_num_q) || stop) state_d = DONE;
        else                                                   state_d = OPT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (metro_exit) begin
      if (is_repl) begin
        ivl_d   = 8'd0;
        state_d = OR_REPL;
      end else begin
        if (repl_q != 8'd0) ivl_d = ivl_q + 8'd1;
        state_d = NEXT;
      end
    end
  end

  // Moore outputs decoded from the upcoming state so they register alongside it.
  always_comb begin
    opt_run_d = (state_d == OPT);
    dis_d     = (state_d == DIST) ? DIS_SEQ[step_d] : DIS_IDLE;
    metro_d   = (state_d == METRO);
    or_repl_d = (state_d == OR_REPL);
    or_exch_d = (state_d == OR_EXCH);
    tw_repl_d = (state_d == TW_REPL);
    tw_exch_d = (state_d == TW_EXCH);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  // State, run context and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      iter_num_q <= '0;
      iter_cnt_q <= '0;
      repl_q     <= 8'd0;
      ivl_q      <= 8'd0;
      opt_q      <= OPT_IDLE;
      step_q     <= 4'd0;
      opt_run_q  <= 1'b0;
      dis_q      <= DIS_IDLE;
      metro_q    <= 1'b0;
      or_repl_q  <= 1'b0;
      tw_repl_q  <= 1'b0;
      or_exch_q  <= 1'b0;
      tw_exch_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_num_q <= iter_num_d;
      iter_cnt_q <= iter_cnt_d;
      repl_q     <= repl_d;
      ivl_q      <= ivl_d;
      opt_q      <= opt_d;
      step_q     <= step_d;
      opt_run_q  <= opt_run_d;
      dis_q      <= dis_d;
      metro_q    <= metro_d;
      or_repl_q  <= or_repl_d;
      tw_repl_q  <= tw_repl_d;
      or_exch_q  <= or_exch_d;
      tw_exch_q  <= tw_exch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign opt_run           = opt_run_q;
  assign opt_com           = opt_q;
  assign or_distance_com   = dis_q;
  assign tw_distance_com   = dis_q;
  assign or_metropolis_run = metro_q;
  assign tw_metropolis_run = metro_q;
  assign or_replica_run    = or_repl_q;
  assign tw_replica_run    = tw_repl_q;
  assign or_exchange_run   = or_exch_q;
  assign tw_exchange_run   = tw_exch_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign iter_cnt          = iter_cnt_q;

endmodule

// File: tb/tb_node_sched.sv
// Self-checking bench for node_sched: reset sequences plus a table of runs checked via a scoreboard.
module tb_node_sched;
  import replica_pkg::*;

  localparam int ITER_W = 24;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ITER_W-1:0] iter_num = '0;
  logic [7:0]        repl_interval = 8'd0;
  opt_command_t      opt_mode = OPT_IDLE;

  logic              opt_run;
  opt_command_t      opt_com;
  distance_command_t or_distance_com, tw_distance_com;
  logic              or_metropolis_run, tw_metropolis_run;
  logic              or_replica_run, tw_replica_run;
  logic              or_exchange_run, tw_exchange_run;
  logic              busy, done;
  logic [ITER_W-1:0] iter_cnt;

  node_sched #(
    .DIS_STEPS (4),
    .METRO_LAT (2),
    .EXCH_LAT  (3),
    .ITER_W    (ITER_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .stop              (stop),
    .iter_num          (iter_num),
    .repl_interval     (repl_interval),
    .opt_mode          (opt_mode),
    .opt_run           (opt_run),
    .opt_com           (opt_com),
    .or_distance_com   (or_distance_com),
    .tw_distance_com   (tw_distance_com),
    .or_metropolis_run (or_metropolis_run),
    .tw_metropolis_run (tw_metropolis_run),
    .or_replica_run    (or_replica_run),
    .tw_replica_run    (tw_replica_run),
    .or_exchange_run   (or_exchange_run),
    .tw_exchange_run   (tw_exchange_run),
    .busy              (busy),
    .done              (done),
    .iter_cnt          (iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ITER_W-1:0] iter_num;
    logic [7:0]        repl;
    opt_command_t      om;
    int                restart_at;
    int                stop_iter;
    int                exp_done;
    logic [ITER_W-1:0] exp_cnt;
    int                exp_opts;
    int                exp_repl;
    int                exp_gap;
    opt_command_t      exp_om;
  } vec_t;

  vec_t vecs[7];
  vec_t exp_q[$];

  int compared = 0;
  int mismatched = 0;

  int rel, done_rel, opt_cnt, opt_first, opt_second;
  int or_cnt, tw_cnt, or_first, tw_first, overlap, dis_bad, pair_bad, busy_at1;
  distance_command_t dis_exp[6];

  function automatic vec_t mk(input int n, input int ri, input int om, input int restart_at,
                              input int stop_iter, input int exp_done, input int exp_cnt,
                              input int exp_opts, input int exp_repl, input int exp_gap,
                              input int exp_om);
    vec_t v;
    v.iter_num   = ITER_W'(n);
    v.repl       = 8'(ri);
    v.om         = opt_command_t'(om);
    v.restart_at = restart_at;
    v.stop_iter  = stop_iter;
    v.exp_done   = exp_done;
    v.exp_cnt    = ITER_W'(exp_cnt);
    v.exp_opts   = exp_opts;
    v.exp_repl   = exp_repl;
    v.exp_gap    = exp_gap;
    v.exp_om     = opt_command_t'(exp_om);
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Drives one start, queues its expectation, and monitors the run until done or budget.
  task automatic applyStimulus(input vec_t v);
    exp_q.push_back(v);
    @(negedge clk);
    iter_num      = v.iter_num;
    repl_interval = v.repl;
    opt_mode      = v.om;
    start         = 1'b1;
    rel = 0; done_rel = -1; opt_cnt = 0; opt_first = -1; opt_second = -1;
    or_cnt = 0; tw_cnt = 0; or_first = -1; tw_first = -1;
    overlap = 0; dis_bad = 0; pair_bad = 0; busy_at1 = 0;
    while (done_rel < 0 && rel < 200) begin
      @(negedge clk);
      rel++;
      if (rel == 1) start = 1'b0;
      if (rel == 2) opt_mode = ~v.om;
      if (v.restart_at != 0 && rel == v.restart_at) begin
        start    = 1'b1;
        iter_num = ITER_W'(1);
      end
      if (v.restart_at != 0 && rel == v.restart_at + 1) start = 1'b0;
      if (opt_run) begin
        opt_cnt++;
        if (opt_first < 0) opt_first = rel;
        else if (opt_second < 0) opt_second = rel;
      end
      if (v.stop_iter != 0 && opt_cnt == v.stop_iter) stop = 1'b1;
      if (or_replica_run) begin
        or_cnt++;
        if (or_first < 0) or_first = rel;
      end
      if (tw_replica_run) begin
        tw_cnt++;
        if (tw_first < 0) tw_first = rel;
      end
      if ((or_replica_run | or_exchange_run) & (tw_replica_run | tw_exchange_run)) overlap++;
      if (or_distance_com != tw_distance_com) pair_bad++;
      if (v.exp_opts > 0 && rel <= 6 && or_distance_com != dis_exp[rel-1]) dis_bad++;
      if (rel == 1) busy_at1 = int'(busy);
      if (done) done_rel = rel;
    end
    stop = 1'b0;
  endtask

  // Pops the oldest expectation and compares it against what the monitor observed.
  task automatic checkVector(input int idx);
    vec_t e;
    e = exp_q.pop_front();
    checkOutput($sformatf("v%0d_done_cycle", idx), done_rel, e.exp_done);
    checkOutput($sformatf("v%0d_iter_cnt", idx), iter_cnt, e.exp_cnt);
    checkOutput($sformatf("v%0d_opt_pulses", idx), opt_cnt, e.exp_opts);
    checkOutput($sformatf("v%0d_or_repl_pulses", idx), or_cnt, e.exp_repl);
    checkOutput($sformatf("v%0d_tw_repl_pulses", idx), tw_cnt, e.exp_repl);
    checkOutput($sformatf("v%0d_or_tw_overlap", idx), overlap, 0);
    checkOutput($sformatf("v%0d_dist_pair", idx), pair_bad, 0);
    checkOutput($sformatf("v%0d_dist_seq", idx), dis_bad, 0);
    checkOutput($sformatf("v%0d_opt_com", idx), opt_com, e.exp_om);
    checkOutput($sformatf("v%0d_busy_first", idx), busy_at1, 1);
    if (e.exp_opts >= 2)
      checkOutput($sformatf("v%0d_opt_gap", idx), opt_second - opt_first, e.exp_gap);
    if (e.exp_repl > 0)
      checkOutput($sformatf("v%0d_tw_after_or", idx), tw_first - or_first, 5);
    @(negedge clk);
    checkOutput($sformatf("v%0d_busy_after", idx), busy, 0);
    checkOutput($sformatf("v%0d_done_after", idx), done, 0);
  endtask

  initial begin
    dis_exp[0] = DIS_IDLE;
    dis_exp[1] = 5'h03;
    dis_exp[2] = 5'h05;
    dis_exp[3] = 5'h09;
    dis_exp[4] = 5'h11;
    dis_exp[5] = DIS_IDLE;

    //            n  ri om rst stp done cnt opts repl gap exp_om
    vecs[0] = mk( 3, 0, 5, 0,  0,  28,  3,  3,   0,   9,  5);
    vecs[1] = mk( 4, 2, 2, 0,  0,  57,  4,  4,   2,   9,  2);
    vecs[2] = mk(10, 0, 1, 0,  2,  19,  2,  2,   0,   9,  1);
    vecs[3] = mk( 3, 0, 6, 5,  0,  28,  3,  3,   0,   9,  6);
    vecs[4] = mk( 0, 3, 7, 0,  0,   1,  3,  0,   0,   0,  6);
    vecs[5] = mk( 2, 1, 3, 0,  0,  39,  2,  2,   2,  19,  3);
    vecs[6] = mk( 5, 3, 4, 0,  0,  56,  5,  5,   1,   9,  4);

    // Power-on reset state.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_iter_cnt", iter_cnt, 0);
    checkOutput("rst_opt_com", opt_com, OPT_IDLE);
    checkOutput("rst_dist", or_distance_com, DIS_IDLE);
    checkOutput("rst_opt_run", opt_run, 0);
    reset = 1'b1;

    // Abort a run with reset while it is in the DIST phase.
    @(negedge clk);
    iter_num = ITER_W'(3); repl_interval = 8'd1; opt_mode = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("mid_dist_active", or_distance_com, 5'h03);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_or_dist", or_distance_com, DIS_IDLE);
    checkOutput("abort_tw_dist", tw_distance_com, DIS_IDLE);
    checkOutput("abort_runs", {opt_run, or_metropolis_run, tw_metropolis_run, or_replica_run,
                               tw_replica_run, or_exchange_run, tw_exchange_run, done}, 0);
    checkOutput("abort_opt_com", opt_com, OPT_IDLE);
    @(negedge clk);
    checkOutput("abort_stays_idle", busy, 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
